mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the request unit's memory handshake: accepts the instruction-read strobe (imemREN) and the data strobes (dmemREN/dmemWEN). It serialises them onto a single-ported RAM with a fixed wait-state count, and returns the one-cycle ihit/dhit pulses plus load data that the request unit and datapath consume. It sits between the core (request unit + datapath) and the RAM model, replacing a combinational memory path with a latency-accurate one.

## Interface

Parameters:
- LAT, default 2: RAM wait states. Legal range 0..15. The transaction holds RAM strobes for LAT+1 cycles.
- AW, default 32: address width in bits.
- DW, default 32: data word width in bits (cpu_types_pkg word_t).

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset. Synchronous, active-high.
- imemREN  in  1  instruction read request.
- imemaddr  in  AW  instruction byte address.
- dmemREN  in  1  data read request.
- dmemWEN  in  1  data write request.
- dmemaddr  in  AW  data byte address.
- dmemstore  in  DW  data write value.
- ihit  out  1  one-cycle pulse: instruction read complete, imemload valid.
- dhit  out  1  one-cycle pulse: data read/write complete, dmemload valid for reads.
- imemload  out  DW  instruction word. Registered and held until the next instruction completion.
- dmemload  out  DW  data read word. Registered and held until the next data read completion.
- ramREN  out  1  RAM read strobe. Registered.
- ramWEN  out  1  RAM write strobe. Registered.
- ramaddr  out  AW  RAM word address: {addr[AW-1:2],2'b00}. Registered.
- ramstore  out  DW  RAM write data. Registered.
- ramload  in  DW  RAM read data, valid in the last strobe cycle.

## Operation

- FSM states: IDLE, BUSY, RESP.
- **IDLE**
  - Sample requests each cycle.
  - If any request is pending, pick a winner, latch its source, type, aligned address and store data into ram* registers, load the counter with LAT, and go to BUSY.
  - With no request, stay in IDLE; all strobes stay 0.
- **Arbitration**
  - Data wins by default.
  - If the last served source was data and imemREN is also pending, the instruction wins (alternating fairness).
  - A last-served flag updates on each RESP.
- **Data request type**
  - dmemWEN=1 means write, regardless of dmemREN.
  - dmemREN and dmemWEN both 1 is illegal; it is treated as a write.
- **BUSY**
  - Exactly one of ramREN/ramWEN is held at 1 and the counter decrements each cycle.
  - When the counter is 0: capture ramload into the destination load register (reads only), drop the strobes at the next edge, and go to RESP.
- **RESP**
  - Assert the served source's hit (ihit or dhit) for exactly one cycle, then go to IDLE.
  - The hit is never asserted in any other state.
- **Request deasserted mid-BUSY:** the transaction still completes and the hit still pulses. The requester ignores it.
- **Request address/data changing mid-BUSY:** ignored, because values were latched in IDLE.
- **Reset (any state, including mid-BUSY):**
  - Next state IDLE.
  - ihit, dhit, ramREN, ramWEN = 0.
  - ramaddr, ramstore, imemload, dmemload = 0.
  - Last-served flag = instruction, so data wins first.
  - A partially strobed write is abandoned.

## Timing

- Request visible in cycle 0 (IDLE):
  - Strobes are high in cycles 1..LAT+1.
  - The hit is high in cycle LAT+2.
  - Earliest next acceptance is in cycle LAT+3, in IDLE.
- Latency by LAT:
  - LAT=0: strobe in cycle 1, hit in cycle 2.
  - LAT=2: strobes in cycles 1–3, hit in cycle 4.
- Throughput: one transaction per LAT+3 cycles.
- Load data is valid in the hit cycle and stable afterwards.
- The requester must update its request on the edge following the hit. The IDLE cycle samples the updated request.
- ramaddr and ramstore are stable for the whole strobe window.

## Test plan

- **Reset:** hold RST 2 cycles with all requests high → all outputs 0 and state IDLE. Release RST with dmemREN=1 and imemREN=1 → ramREN rises next cycle and ramaddr shows the data address (data first).
- **Instruction read, LAT=2:** imemREN=1, imemaddr=0x0000_0043, ramload=0xDEAD_BEEF → ramaddr=0x0000_0040, ramREN high cycles 1–3, ihit single pulse in cycle 4, imemload=0xDEAD_BEEF held.
- **Data write, LAT=0:** dmemWEN=1, dmemaddr=0x100, dmemstore=0x1234_5678 → ramWEN high in cycle 1 only, ramstore=0x1234_5678, dhit pulse in cycle 2, dmemload unchanged.
- **Fairness:** imemREN and dmemREN both held high continuously → served order D, I, D, I. hit pulses alternate dhit/ihit every LAT+3 cycles. Neither source is starved.
- **Abort and illegal cases:**
  - dmemREN dropped in cycle 2 of BUSY → dhit still pulses in cycle LAT+2.
  - dmemREN=dmemWEN=1 → ramWEN asserted, ramREN never asserted.
- **Reset mid-BUSY:** RST asserted in cycle 2 of a write → ramWEN 0 the next cycle and no dhit. After release, a fresh request completes with normal latency.

Source files
------------

// File: rtl/mem_responder.sv
// ============================================================================
// Module   : mem_responder
// Purpose  : Serialises instruction and data requests onto a single-ported RAM
//            with LAT wait states and returns one-cycle ihit/dhit pulses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_responder #(
  parameter int LAT = 2,
  parameter int AW  = 32,
  parameter int DW  = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          imemREN,
  input  logic [AW-1:0] imemaddr,
  input  logic          dmemREN,
  input  logic          dmemWEN,
  input  logic [AW-1:0] dmemaddr,
  input  logic [DW-1:0] dmemstore,
  output logic          ihit,
  output logic          dhit,
  output logic [DW-1:0] imemload,
  output logic [DW-1:0] dmemload,
  output logic          ramREN,
  output logic          ramWEN,
  output logic [AW-1:0] ramaddr,
  output logic [DW-1:0] ramstore,
  input  logic [DW-1:0] ramload
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] c_lat = 4'(LAT);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_src_i;
  logic       r_last_d;

  logic w_dreq;
  logic w_any;
  logic w_pick_i;
  logic w_unused_lsbs;

  assign w_dreq        = dmemREN | dmemWEN;
  assign w_any         = imemREN | w_dreq;
  // Instruction wins only when data was served last or no data request exists.
  assign w_pick_i      = imemREN & (r_last_d | ~w_dreq);
  assign w_unused_lsbs = ^{imemaddr[1:0], dmemaddr[1:0]};

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_src_i  <= 1'b0;
      r_last_d <= 1'b0;
      ihit     <= 1'b0;
      dhit     <= 1'b0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      imemload <= '0;
      dmemload <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          ihit <= 1'b0;
          dhit <= 1'b0;
          if (w_any) begin
            r_src_i <= w_pick_i;
            r_cnt   <= c_lat;
            r_state <= BUSY;
            if (w_pick_i) begin
              ramREN  <= 1'b1;
              ramWEN  <= 1'b0;
              ramaddr <= {imemaddr[AW-1:2], 2'b00};
            end else begin
              // A simultaneous read+write is resolved as a write.
              ramREN   <= ~dmemWEN;
              ramWEN   <= dmemWEN;
              ramaddr  <= {dmemaddr[AW-1:2], 2'b00};
              ramstore <= dmemstore;
            end
          end
        end
        BUSY: begin
          if (r_cnt == 4'd0) begin
            if (ramREN) begin
              if (r_src_i) imemload <= ramload;
              else         dmemload <= ramload;
            end
            ramREN  <= 1'b0;
            ramWEN  <= 1'b0;
            ihit    <= r_src_i;
            dhit    <= ~r_src_i;
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          ihit     <= 1'b0;
          dhit     <= 1'b0;
          r_last_d <= ~r_src_i;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Directed self-checking bench with a load-data scoreboard for
//            mem_responder at LAT=2 and LAT=0.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_responder;

  logic clk;
  logic rst;

  // LAT=2 instance signals
  logic        imemREN, dmemREN, dmemWEN;
  logic [31:0] imemaddr, dmemaddr, dmemstore;
  logic        ihit, dhit, ramREN, ramWEN;
  logic [31:0] imemload, dmemload, ramaddr, ramstore, ramload;

  // LAT=0 instance signals
  logic        z_imemREN, z_dmemREN, z_dmemWEN;
  logic [31:0] z_imemaddr, z_dmemaddr, z_dmemstore;
  logic        z_ihit, z_dhit, z_ramREN, z_ramWEN;
  logic [31:0] z_imemload, z_dmemload, z_ramaddr, z_ramstore, z_ramload;

  logic        fix_en;
  logic [31:0] fix_val;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit          is_i;
    bit          is_rd;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign ramload   = fix_en ? fix_val : mem_f(ramaddr);
  assign z_ramload = mem_f(z_ramaddr);

  mem_responder #(.LAT(2), .AW(32), .DW(32)) dut (
    .CLK(clk), .RST(rst),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .ihit(ihit), .dhit(dhit), .imemload(imemload), .dmemload(dmemload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload)
  );

  mem_responder #(.LAT(0), .AW(32), .DW(32)) dut0 (
    .CLK(clk), .RST(rst),
    .imemREN(z_imemREN), .imemaddr(z_imemaddr),
    .dmemREN(z_dmemREN), .dmemWEN(z_dmemWEN), .dmemaddr(z_dmemaddr), .dmemstore(z_dmemstore),
    .ihit(z_ihit), .dhit(z_dhit), .imemload(z_imemload), .dmemload(z_dmemload),
    .ramREN(z_ramREN), .ramWEN(z_ramWEN), .ramaddr(z_ramaddr), .ramstore(z_ramstore),
    .ramload(z_ramload)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every hit pops the oldest expected transaction.
  always @(negedge clk) begin
    if (!rst && (ihit || dhit)) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_hit", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_src_ihit", 32'(ihit), 32'(e.is_i));
        chk("sb_src_dhit", 32'(dhit), 32'(!e.is_i));
        if (e.is_rd) chk("sb_load", e.is_i ? imemload : dmemload, e.data);
      end
    end
  end

  initial begin
    rst = 1'b1;
    fix_en = 1'b0; fix_val = '0;
    imemREN = 1'b1; dmemREN = 1'b1; dmemWEN = 1'b0;
    imemaddr = 32'h200; dmemaddr = 32'h307; dmemstore = 32'h0;
    z_imemREN = 1'b0; z_dmemREN = 1'b0; z_dmemWEN = 1'b0;
    z_imemaddr = '0; z_dmemaddr = '0; z_dmemstore = '0;

    // Reset held with all requests high
    repeat (2) step();
    chk("rst_ihit", 32'(ihit), 32'd0);
    chk("rst_dhit", 32'(dhit), 32'd0);
    chk("rst_ramREN", 32'(ramREN), 32'd0);
    chk("rst_ramWEN", 32'(ramWEN), 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_ramstore", ramstore, 32'd0);
    chk("rst_imemload", imemload, 32'd0);
    chk("rst_dmemload", dmemload, 32'd0);

    // Fairness: both held high, expect D, I, D, I every 5 cycles
    rst = 1'b0;
    sb.push_back('{is_i: 1'b0, is_rd: 1'b1, data: mem_f(32'h304)});
    sb.push_back('{is_i: 1'b1, is_rd: 1'b1, data: mem_f(32'h200)});
    sb.push_back('{is_i: 1'b0, is_rd: 1'b1, data: mem_f(32'h304)});
    sb.push_back('{is_i: 1'b1, is_rd: 1'b1, data: mem_f(32'h200)});
    for (int c = 1; c <= 19; c++) begin
      int m;
      step();
      m = c % 5;
      chk("fair_dhit", 32'(dhit), 32'(c == 4 || c == 14));
      chk("fair_ihit", 32'(ihit), 32'(c == 9 || c == 19));
      chk("fair_ramREN", 32'(ramREN), 32'(m >= 1 && m <= 3));
      chk("fair_ramWEN", 32'(ramWEN), 32'd0);
      if (m >= 1 && m <= 3)
        chk("fair_ramaddr", ramaddr, (c < 5 || (c >= 10 && c < 15)) ? 32'h304 : 32'h200);
      if (c == 19) begin
        imemREN = 1'b0;
        dmemREN = 1'b0;
      end
    end
    repeat (2) begin
      step();
      chk("fair_idle_ramREN", 32'(ramREN), 32'd0);
    end

    // Instruction read with unaligned address
    fix_en = 1'b1; fix_val = 32'hDEAD_BEEF;
    imemaddr = 32'h43; imemREN = 1'b1;
    sb.push_back('{is_i: 1'b1, is_rd: 1'b1, data: 32'hDEAD_BEEF});
    for (int c = 1; c <= 6; c++) begin
      step();
      chk("ird_ihit", 32'(ihit), 32'(c == 4));
      chk("ird_ramREN", 32'(ramREN), 32'(c <= 3));
      if (c <= 3) chk("ird_ramaddr", ramaddr, 32'h40);
      if (c >= 4) chk("ird_imemload", imemload, 32'hDEAD_BEEF);
      if (c == 4) imemREN = 1'b0;
    end
    fix_en = 1'b0;

    // Data read whose request drops mid-transaction
    dmemaddr = 32'h88; dmemREN = 1'b1;
    sb.push_back('{is_i: 1'b0, is_rd: 1'b1, data: mem_f(32'h88)});
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 2) dmemREN = 1'b0;
      chk("abort_dhit", 32'(dhit), 32'(c == 4));
      chk("abort_ramREN", 32'(ramREN), 32'(c <= 3));
    end

    // Illegal read+write treated as a write
    dmemaddr = 32'h1C; dmemstore = 32'hCAFE_F00D; dmemREN = 1'b1; dmemWEN = 1'b1;
    sb.push_back('{is_i: 1'b0, is_rd: 1'b0, data: 32'h0});
    for (int c = 1; c <= 5; c++) begin
      step();
      chk("ill_ramREN", 32'(ramREN), 32'd0);
      chk("ill_ramWEN", 32'(ramWEN), 32'(c <= 3));
      if (c <= 3) begin
        chk("ill_ramstore", ramstore, 32'hCAFE_F00D);
        chk("ill_ramaddr", ramaddr, 32'h1C);
      end
      chk("ill_dhit", 32'(dhit), 32'(c == 4));
      if (c == 4) begin
        chk("ill_dmemload_held", dmemload, mem_f(32'h88));
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
      end
    end

    // Reset during a write
    dmemaddr = 32'h50; dmemstore = 32'h1111_2222; dmemWEN = 1'b1;
    step();
    chk("rbusy_ramWEN_c1", 32'(ramWEN), 32'd1);
    step();
    rst = 1'b1;
    dmemWEN = 1'b0;
    step();
    chk("rbusy_ramWEN", 32'(ramWEN), 32'd0);
    chk("rbusy_ramaddr", ramaddr, 32'd0);
    chk("rbusy_ramstore", ramstore, 32'd0);
    chk("rbusy_dmemload", dmemload, 32'd0);
    rst = 1'b0;
    repeat (3) begin
      step();
      chk("rbusy_no_dhit", 32'(dhit), 32'd0);
    end
    dmemaddr = 32'h60; dmemREN = 1'b1;
    sb.push_back('{is_i: 1'b0, is_rd: 1'b1, data: mem_f(32'h60)});
    for (int c = 1; c <= 5; c++) begin
      step();
      chk("fresh_dhit", 32'(dhit), 32'(c == 4));
      chk("fresh_ramREN", 32'(ramREN), 32'(c <= 3));
      if (c == 4) dmemREN = 1'b0;
    end

    // LAT=0 write
    z_dmemaddr = 32'h100; z_dmemstore = 32'h1234_5678; z_dmemWEN = 1'b1;
    step();
    chk("l0w_ramWEN_c1", 32'(z_ramWEN), 32'd1);
    chk("l0w_ramstore", z_ramstore, 32'h1234_5678);
    chk("l0w_ramaddr", z_ramaddr, 32'h100);
    chk("l0w_dhit_c1", 32'(z_dhit), 32'd0);
    step();
    chk("l0w_ramWEN_c2", 32'(z_ramWEN), 32'd0);
    chk("l0w_dhit_c2", 32'(z_dhit), 32'd1);
    chk("l0w_dmemload", z_dmemload, 32'd0);
    z_dmemWEN = 1'b0;
    step();
    chk("l0w_dhit_c3", 32'(z_dhit), 32'd0);

    // LAT=0 read, unaligned
    z_dmemaddr = 32'h107; z_dmemREN = 1'b1;
    step();
    chk("l0r_ramREN_c1", 32'(z_ramREN), 32'd1);
    chk("l0r_ramaddr", z_ramaddr, 32'h104);
    step();
    chk("l0r_dhit_c2", 32'(z_dhit), 32'd1);
    chk("l0r_dmemload", z_dmemload, mem_f(32'h104));
    chk("l0r_ihit_c2", 32'(z_ihit), 32'd0);
    z_dmemREN = 1'b0;
    step();
    chk("l0r_dhit_c3", 32'(z_dhit), 32'd0);
    chk("l0r_ramREN_c3", 32'(z_ramREN), 32'd0);

    step();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
